// File: rtl/store_queue.sv
// rtl/store_queue.sv - in-order store queue draining committed stores to data memory
// Optional load forwarding from queued stores is enabled by defining STORE_FORWARD_EN.
module store_queue #(
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
) (
  input  logic                     CLOCK_50,
  input  logic                     RSTN_N,
  input  logic                     commit_valid,
  input  logic [ADDR_W-1:0]        commit_addr,
  input  logic [DATA_W-1:0]        commit_data,
  output logic                     commit_ready,
  output logic                     mem_req,
  output logic [ADDR_W-1:0]        mem_addr,
  output logic [DATA_W-1:0]        mem_data,
  input  logic                     mem_ack,
  input  logic [ADDR_W-1:0]        ld_addr,
  output logic                     ld_hit,
  output logic [DATA_W-1:0]        ld_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

  typedef enum logic {IDLE, REQ} state_t;

  state_t             state_q, state_d;
  logic [PTR_W-1:0]   head_q, head_d;
  logic [PTR_W-1:0]   tail_q, tail_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               empty_q, empty_d;

  logic [ADDR_W-1:0]  addr_q [DEPTH];
  logic [DATA_W-1:0]  data_q [DEPTH];

  logic push, pop;

  assign commit_ready = (count_q != CNT_FULL);
  assign push         = commit_valid && commit_ready;
  assign pop          = (state_q == REQ) && mem_ack;

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    state_d = state_q;
    if (push) tail_d = tail_q + PTR_ONE;
    if (pop)  head_d = head_q + PTR_ONE;
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
    empty_d = (count_d == '0);
    // Request tracks occupancy after this edge, so a push into an empty queue requests next cycle.
    case (state_q)
      IDLE:    if (!empty_d) state_d = REQ;
      REQ:     if (pop && empty_d) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_50 or negedge RSTN_N) begin
    if (!RSTN_N) begin
      state_q <= IDLE;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      empty_q <= 1'b1;
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      empty_q <= empty_d;
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (push) begin
      addr_q[tail_q] <= commit_addr;
      data_q[tail_q] <= commit_data;
    end
  end

  assign mem_req  = (state_q == REQ);
  assign mem_addr = mem_req ? addr_q[head_q] : '0;
  assign mem_data = mem_req ? data_q[head_q] : '0;
  assign count    = count_q;
  assign empty    = empty_q;

`ifdef STORE_FORWARD_EN
  logic [PTR_W-1:0] fwd_idx;

  // Scan oldest to youngest so the youngest match overrides earlier ones.
  always_comb begin
    ld_hit  = 1'b0;
    ld_data = '0;
    fwd_idx = head_q;
    for (int i = 0; i < DEPTH; i++) begin
      fwd_idx = head_q + PTR_W'(i);
      if ((CNT_W'(i) < count_q) && (addr_q[fwd_idx] == ld_addr)) begin
        ld_hit  = 1'b1;
        ld_data = data_q[fwd_idx];
      end
    end
  end
`else
  logic unused_ld_addr;

  assign unused_ld_addr = ^ld_addr;
  assign ld_hit         = 1'b0;
  assign ld_data        = '0;
`endif

endmodule

// File: tb/tb_store_queue.sv
// tb/tb_store_queue.sv - scoreboard bench for store_queue
module tb_store_queue;

  typedef struct packed {
    logic [9:0]  a;
    logic [31:0] d;
  } ent_t;

  logic        CLOCK_50 = 1'b0;
  logic        RSTN_N;
  logic        commit_valid;
  logic [9:0]  commit_addr;
  logic [31:0] commit_data;
  logic        commit_ready;
  logic        mem_req;
  logic [9:0]  mem_addr;
  logic [31:0] mem_data;
  logic        mem_ack;
  logic [9:0]  ld_addr;
  logic        ld_hit;
  logic [31:0] ld_data;
  logic [3:0]  count;
  logic        empty;

  ent_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   drained = 0;
  bit   accepted;

  store_queue dut (
    .CLOCK_50    (CLOCK_50),
    .RSTN_N      (RSTN_N),
    .commit_valid(commit_valid),
    .commit_addr (commit_addr),
    .commit_data (commit_data),
    .commit_ready(commit_ready),
    .mem_req     (mem_req),
    .mem_addr    (mem_addr),
    .mem_data    (mem_data),
    .mem_ack     (mem_ack),
    .ld_addr     (ld_addr),
    .ld_hit      (ld_hit),
    .ld_data     (ld_data),
    .count       (count),
    .empty       (empty)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock, updating the scoreboard from the handshakes seen before the edge.
  task automatic cycle();
    ent_t e;
    bit do_push, do_pop;
    do_push = commit_valid && commit_ready;
    do_pop  = mem_req && mem_ack;
    if (do_pop) begin
      if (sb.size() == 0) begin
        chk("pop_with_empty_model", 1, 0);
      end else begin
        e = sb.pop_front();
        chk("mem_addr", 64'(mem_addr), 64'(e.a));
        chk("mem_data", 64'(mem_data), 64'(e.d));
        drained++;
      end
    end
    if (do_push) sb.push_back('{a: commit_addr, d: commit_data});
    accepted = do_push;
    @(posedge CLOCK_50);
    #1;
    chk("count", 64'(count), 64'(sb.size()));
    chk("empty", 64'(empty), 64'(sb.size() == 0));
    chk("mem_req", 64'(mem_req), 64'(sb.size() != 0));
    chk("commit_ready", 64'(commit_ready), 64'(sb.size() != 8));
  endtask

  function automatic logic [32:0] fwd_model(input logic [9:0] a);
    logic [32:0] r;
    r = '0;
`ifdef STORE_FORWARD_EN
    foreach (sb[i]) if (sb[i].a == a) r = {1'b1, sb[i].d};
`endif
    return r;
  endfunction

  task automatic push_one(input logic [9:0] a, input logic [31:0] d);
    commit_valid = 1'b1;
    commit_addr  = a;
    commit_data  = d;
    cycle();
    commit_valid = 1'b0;
  endtask

  task automatic drain_all();
    int n;
    mem_ack = 1'b1;
    n = 0;
    while (sb.size() != 0 && n < 50) begin
      cycle();
      n++;
    end
    mem_ack = 1'b0;
    chk("drain_bound", 64'(sb.size()), 0);
  endtask

  initial begin
    RSTN_N       = 1'b0;
    commit_valid = 1'b0;
    commit_addr  = '0;
    commit_data  = '0;
    mem_ack      = 1'b0;
    ld_addr      = '0;
    @(posedge CLOCK_50);
    #1;
    chk("rst_mem_req", 64'(mem_req), 0);
    chk("rst_mem_addr", 64'(mem_addr), 0);
    chk("rst_mem_data", 64'(mem_data), 0);
    chk("rst_count", 64'(count), 0);
    chk("rst_empty", 64'(empty), 1);
    chk("rst_commit_ready", 64'(commit_ready), 1);
    chk("rst_ld_hit", 64'(ld_hit), 0);
    chk("rst_ld_data", 64'(ld_data), 0);
    RSTN_N = 1'b1;
    cycle();

    // Single store: request appears exactly one cycle after the push.
    chk("single_req_before", 64'(mem_req), 0);
    push_one(10'h005, 32'h2A);
    chk("single_req", 64'(mem_req), 1);
    chk("single_addr", 64'(mem_addr), 64'h005);
    chk("single_data", 64'(mem_data), 64'h2A);
    mem_ack = 1'b1;
    cycle();
    mem_ack = 1'b0;
    chk("single_empty", 64'(empty), 1);

    // Fill to full, drop a ninth push, then one ack reopens the queue.
    for (int i = 0; i < 8; i++) push_one(10'h100 + 10'(i), 32'h200 + 32'(i));
    chk("full_count", 64'(count), 8);
    chk("full_ready", 64'(commit_ready), 0);
    push_one(10'h3FF, 32'hDEAD);
    chk("ninth_dropped", 64'(accepted), 0);
    chk("ninth_count", 64'(count), 8);
    mem_ack = 1'b1;
    chk("pop_cycle_ready", 64'(commit_ready), 0);
    cycle();
    chk("ready_after_ack", 64'(commit_ready), 1);
    for (int i = 0; i < 4; i++) cycle();
    mem_ack = 1'b0;
    chk("count_three", 64'(count), 3);

    // Simultaneous push and pop keeps occupancy and advances the head.
    mem_ack      = 1'b1;
    commit_valid = 1'b1;
    commit_addr  = 10'h1F0;
    commit_data  = 32'hABC;
    cycle();
    commit_valid = 1'b0;
    mem_ack      = 1'b0;
    chk("pushpop_count", 64'(count), 3);
    chk("pushpop_head", 64'(mem_data), 64'(sb[0].d));
    drain_all();

    // Forwarding lookups against the queued stores.
    push_one(10'h010, 32'd7);
    push_one(10'h011, 32'd9);
    push_one(10'h010, 32'd12);
    ld_addr = 10'h010;
    #1;
    chk("fwd_hit_010", 64'(ld_hit), 64'(fwd_model(10'h010) >> 32));
    chk("fwd_data_010", 64'(ld_data), 64'(fwd_model(10'h010) & 33'hFFFFFFFF));
    ld_addr = 10'h011;
    #1;
    chk("fwd_data_011", 64'(ld_data), 64'(fwd_model(10'h011) & 33'hFFFFFFFF));
    ld_addr = 10'h012;
    #1;
    chk("fwd_hit_012", 64'(ld_hit), 0);
    chk("fwd_data_012", 64'(ld_data), 0);
    drain_all();

    // Twenty stores under random acks; scoreboard enforces commit order.
    begin
      int sent, n;
      sent = 0;
      n = 0;
      drained = 0;
      while ((sent < 20 || sb.size() != 0) && n < 400) begin
        commit_valid = (sent < 20);
        commit_addr  = 10'(sent * 3);
        commit_data  = 32'(sent + 1);
        mem_ack      = 1'($urandom_range(0, 1));
        cycle();
        if (accepted) sent++;
        n++;
      end
      commit_valid = 1'b0;
      mem_ack      = 1'b0;
      chk("order_sent", 64'(sent), 20);
      chk("order_drained", 64'(drained), 20);
    end

    // Asynchronous reset in the middle of a drain.
    for (int i = 0; i < 4; i++) push_one(10'h040 + 10'(i), 32'h500 + 32'(i));
    chk("middrain_req", 64'(mem_req), 1);
    #2;
    RSTN_N = 1'b0;
    #1;
    chk("async_mem_req", 64'(mem_req), 0);
    chk("async_count", 64'(count), 0);
    chk("async_empty", 64'(empty), 1);
    sb.delete();
    @(negedge CLOCK_50);
    RSTN_N  = 1'b1;
    mem_ack = 1'b1;
    cycle();
    mem_ack = 1'b0;
    chk("post_rst_empty", 64'(empty), 1);
    chk("post_rst_req", 64'(mem_req), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/store_queue.md
STORE_QUEUE -- requirements
Module: store_queue

Interface
REQ-001 Parameter DEPTH, default 8, number of store entries; SHALL be a power of two, range 2..64.
REQ-002 Parameter ADDR_W, default 10, word address width; covers 1024-word data memory.
REQ-003 Parameter DATA_W, default 32, store data width.
REQ-004 Ports SHALL be exactly as follows; one clock, CLOCK_50; reset RSTN_N is asynchronous and active-low.
- CLOCK_50  in  1  sole clock, rising edge.
- RSTN_N  in  1  asynchronous active-low reset.
- commit_valid  in  1  reorder-buffer commit presents a store this cycle.
- commit_addr  in  ADDR_W  store word address.
- commit_data  in  DATA_W  store data.
- commit_ready  out  1  queue can accept a store (not full).
- mem_req  out  1  write request to data memory.
- mem_addr  out  ADDR_W  head entry address.
- mem_data  out  DATA_W  head entry data.
- mem_ack  in  1  memory accepted the head write this cycle.
- ld_addr  in  ADDR_W  load lookup address.
- ld_hit  out  1  a queued store matches ld_addr.
- ld_data  out  DATA_W  data of the youngest matching store.
- count  out  $clog2(DEPTH)+1  occupied entries.
- empty  out  1  count == 0; the halt path SHALL wait on this before stopping the clock.

Function
REQ-005 Storage SHALL be a circular FIFO of DEPTH entries {addr, data}, with head/tail pointers wrapping modulo DEPTH and a separate occupancy counter.
REQ-006 Push SHALL occur on a rising edge where commit_valid && commit_ready; the entry is written at tail, and tail increments.
REQ-007 commit_ready SHALL equal (count != DEPTH), derived from registered count; commit_valid while not ready is dropped, and the commit stage SHALL NOT advance.
REQ-008 Write-port FSM states: IDLE, REQ.
- IDLE -> REQ on any edge where count (after that edge's update) > 0.
- In REQ, mem_req = 1 and mem_addr/mem_data = head entry, held stable until mem_ack.
- mem_ack in REQ pops the head; next state is REQ if entries remain after the pop and push, else IDLE.
- mem_ack in IDLE SHALL be ignored.
REQ-009 Latency: a push into an empty queue SHALL raise mem_req on the next cycle; back-to-back acks SHALL drain one entry per cycle.
REQ-010 Simultaneous push and pop SHALL leave count unchanged; both pointers advance.
REQ-011 Full with pop: commit_ready is low that cycle, so no push occurs; it rises on the following cycle.
REQ-012 Stores SHALL reach memory in commit order; no entry is dropped, merged or reordered.
REQ-013 count and empty SHALL be registered and consistent with the pointers every cycle.
REQ-014 Committed stores are architectural: branch-mispredict flush SHALL NOT affect queue contents.

Reset
REQ-015 RSTN_N low SHALL asynchronously clear head, tail and count to 0 and set the FSM to IDLE, mem_req = 0, mem_addr = 0, mem_data = 0, ld_hit = 0, ld_data = 0, empty = 1, commit_ready = 1.
REQ-016 A reset during REQ SHALL drop mem_req immediately and discard all entries; a mem_ack in the first cycle after reset SHALL be ignored.

Configuration
REQ-017 Macro STORE_FORWARD_EN.
- Defined: ld_hit/ld_data are combinational from ld_addr. The search covers all occupied entries, including the head under request. The youngest (closest to tail) match wins. An entry being pushed in the same cycle is not visible.
- Undefined: no comparators; ld_hit = 0 and ld_data = 0 constantly. The load path stalls on !empty instead.

Verification
REQ-018 Single store: push addr 0x005/data 0x0000002A into the empty queue, mem_ack the cycle after mem_req rises -> mem_req is high exactly one cycle later than the push, mem_addr=0x005, mem_data=0x2A, then empty=1.
REQ-019 Fill/full: push 8 stores with mem_ack held 0 -> count=8, commit_ready=0. A 9th push is dropped. One ack -> commit_ready=1 the next cycle.
REQ-020 Order and wrap: push 20 stores (data 1..20) with mem_ack random ~50% -> memory receives data 1..20 in order; pointers wrap at least twice.
REQ-021 Simultaneous push/pop at count=3 -> count stays 3; head data advances.
REQ-022 Forwarding (STORE_FORWARD_EN): queue {0x010:7, 0x011:9, 0x010:12}, ld_addr=0x010 -> ld_hit=1, ld_data=12. ld_addr=0x012 -> ld_hit=0. Undefined build -> ld_hit=0 always.
REQ-023 Reset mid-drain: 4 entries, mem_req high, assert RSTN_N low between edges -> mem_req=0 and count=0 without waiting for an edge; after release, empty=1.
